// File: rtl/jump_sequencer.sv
// jump_sequencer
//   Program-counter sequencer for the MicroUAZ core. It owns the instruction
//   address, runs the FETCH/DECODE handshake with instruction memory, resolves
//   the 3-bit jump code against the ALU flags and a signed relative offset,
//   and keeps a small LIFO return-address stack for CALL/RET.
//
// Ports
//   i_Clk                     system clock, rising edge
//   i_Reset                   synchronous, active-high reset
//   i_Offset[7:0]             signed relative jump offset (RX register)
//   i_Flags[2:0]              {N, C, Z} ALU flags
//   i_ControlJump[2:0]        jump code from the decoder
//   i_Valid                   decoder presents a valid instruction
//   i_MemReady                instruction memory returned the current word
//   o_Addressinstruction_Bus  current PC
//   o_Fetch                   fetch request to instruction memory
//   o_Flush                   one-cycle pulse after a taken branch
//   o_Halted                  sequencer stopped on a stack error
//   o_StackOverflow           sticky: CALL issued with the stack full
//   o_StackUnderflow          sticky: RET issued with the stack empty

module jump_sequencer #(
  parameter int                ADDR_W       = 9,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic [7:0]        i_Offset,
  input  logic [2:0]        i_Flags,
  input  logic [2:0]        i_ControlJump,
  input  logic              i_Valid,
  input  logic              i_MemReady,
  output logic [ADDR_W-1:0] o_Addressinstruction_Bus,
  output logic              o_Fetch,
  output logic              o_Flush,
  output logic              o_Halted,
  output logic              o_StackOverflow,
  output logic              o_StackUnderflow
);

  // Stack pointer must represent 0..STACK_DEPTH inclusive (empty..full).
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_HALT   = 2'd2;

  localparam logic [2:0] JC_NOP  = 3'b000;
  localparam logic [2:0] JC_JMP  = 3'b001;
  localparam logic [2:0] JC_JZ   = 3'b010;
  localparam logic [2:0] JC_JNZ  = 3'b011;
  localparam logic [2:0] JC_JC   = 3'b100;
  localparam logic [2:0] JC_JN   = 3'b101;
  localparam logic [2:0] JC_CALL = 3'b110;
  localparam logic [2:0] JC_RET  = 3'b111;

  localparam logic [SP_W-1:0] SP_EMPTY = '0;
  localparam logic [SP_W-1:0] SP_FULL  = SP_W'(STACK_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stack_d [STACK_DEPTH];
  logic              flush_q, flush_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic signed [7:0] offset_s;
  logic [ADDR_W-1:0] offset_ext;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pop_addr;
  logic              cond_taken;

  logic flag_z, flag_c, flag_n;

  assign flag_z = i_Flags[0];
  assign flag_c = i_Flags[1];
  assign flag_n = i_Flags[2];

  // Address arithmetic: sign-extend the offset to the PC width; the adder
  // width itself gives the modulo-2^ADDR_W wrap in both directions.
  assign offset_s   = i_Offset;
  assign offset_ext = ADDR_W'(offset_s);
  assign pc_plus1   = pc_q + ADDR_W'(1);
  assign target     = pc_q + offset_ext;

  // Conditional branch evaluation for the plain jump codes. CALL and RET are
  // handled separately because their outcome depends on the stack.
  always_comb begin
    cond_taken = 1'b0;
    case (i_ControlJump)
      JC_JMP:  cond_taken = 1'b1;
      JC_JZ:   cond_taken = flag_z;
      JC_JNZ:  cond_taken = ~flag_z;
      JC_JC:   cond_taken = flag_c;
      JC_JN:   cond_taken = flag_n;
      default: cond_taken = 1'b0;
    endcase
  end

  // Top-of-stack read. The loop compares against sp-1 instead of indexing
  // so the pointer width never has to match the array index width.
  always_comb begin
    pop_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) begin
        pop_addr = stack_q[i];
      end
    end
  end

  // Next-state logic. The PC, stack and flush pulse only move on the edge
  // that resolves a valid instruction in DECODE; FETCH merely waits for
  // memory, and HALT holds everything until reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    stack_d = stack_q;
    flush_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    case (state_q)
      ST_FETCH: begin
        if (i_MemReady) begin
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (i_Valid) begin
          state_d = ST_FETCH;
          case (i_ControlJump)
            JC_CALL: begin
              if (sp_q == SP_FULL) begin
                ovf_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                  if (sp_q == SP_W'(i)) begin
                    stack_d[i] = pc_plus1;
                  end
                end
                sp_d    = sp_q + SP_W'(1);
                pc_d    = target;
                flush_d = 1'b1;
              end
            end

            JC_RET: begin
              if (sp_q == SP_EMPTY) begin
                unf_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                sp_d    = sp_q - SP_W'(1);
                pc_d    = pop_addr;
                flush_d = 1'b1;
              end
            end

            default: begin
              if (cond_taken) begin
                pc_d    = target;
                flush_d = 1'b1;
              end else begin
                pc_d = pc_plus1;
              end
            end
          endcase
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      // Unused encoding: recover into a fresh fetch of the current PC.
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State registers with synchronous reset. Stack contents are cleared too
  // so a post-reset image is fully deterministic.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      sp_q    <= SP_EMPTY;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  // The fetch request is masked during the reset cycle itself so memory
  // never sees a request for a PC that is about to be discarded.
  assign o_Fetch                  = (state_q == ST_FETCH) && !i_Reset;
  assign o_Addressinstruction_Bus = pc_q;
  assign o_Flush                  = flush_q;
  assign o_Halted                 = (state_q == ST_HALT);
  assign o_StackOverflow          = ovf_q;
  assign o_StackUnderflow         = unf_q;

endmodule

// File: tb/tb_jump_sequencer.sv
// tb_jump_sequencer
//   Scoreboard bench for jump_sequencer. The driver issues directed
//   instructions and queues the hand-computed response; a monitor pops and
//   compares each time the DUT completes a resolution (re-entering FETCH or
//   entering HALT), and between those points checks that the PC is stable
//   and no flush is pulsing.

module tb_jump_sequencer;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] JMP  = 3'b001;
  localparam logic [2:0] JZ   = 3'b010;
  localparam logic [2:0] JNZ  = 3'b011;
  localparam logic [2:0] JC   = 3'b100;
  localparam logic [2:0] JN   = 3'b101;
  localparam logic [2:0] CALL = 3'b110;
  localparam logic [2:0] RET  = 3'b111;

  logic       i_Clk;
  logic       i_Reset;
  logic [7:0] i_Offset;
  logic [2:0] i_Flags;
  logic [2:0] i_ControlJump;
  logic       i_Valid;
  logic       i_MemReady;
  logic [8:0] o_Addressinstruction_Bus;
  logic       o_Fetch;
  logic       o_Flush;
  logic       o_Halted;
  logic       o_StackOverflow;
  logic       o_StackUnderflow;

  typedef struct {
    string      name;
    logic [8:0] pc;
    logic       fetch;
    logic       flush;
    logic       halted;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t exp_q[$];

  int assert_count = 0;
  int fail_count   = 0;

  jump_sequencer #(
    .ADDR_W       (9),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (9'd0)
  ) dut (
    .i_Clk                    (i_Clk),
    .i_Reset                  (i_Reset),
    .i_Offset                 (i_Offset),
    .i_Flags                  (i_Flags),
    .i_ControlJump            (i_ControlJump),
    .i_Valid                  (i_Valid),
    .i_MemReady               (i_MemReady),
    .o_Addressinstruction_Bus (o_Addressinstruction_Bus),
    .o_Fetch                  (o_Fetch),
    .o_Flush                  (o_Flush),
    .o_Halted                 (o_Halted),
    .o_StackOverflow          (o_StackOverflow),
    .o_StackUnderflow         (o_StackUnderflow)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input string name, input logic [8:0] pc, input logic fetch,
                              input logic flush, input logic halted, input logic ovf,
                              input logic unf);
    exp_t e;
    e.name   = name;
    e.pc     = pc;
    e.fetch  = fetch;
    e.flush  = flush;
    e.halted = halted;
    e.ovf    = ovf;
    e.unf    = unf;
    exp_q.push_back(e);
  endtask

  // Synchronous reset for one edge; the fetch request must be masked while
  // reset is asserted, and the post-reset image is queued for the monitor.
  task automatic resetDut(input string name);
    i_Reset    = 1'b1;
    i_Valid    = 1'b0;
    i_MemReady = 1'b0;
    pushExpected(name, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge i_Clk);
    checkOutput({name, "_fetch_during_reset"}, int'(o_Fetch), 0);
    @(posedge i_Clk);
    #1;
    i_Reset = 1'b0;
  endtask

  // One instruction: optional memory wait, one FETCH cycle with MemReady
  // (plus a junk valid instruction that FETCH must ignore), then one DECODE
  // cycle carrying the real instruction.
  task automatic applyStimulus(input string name, input logic [2:0] code, input logic [7:0] off,
                               input logic [2:0] flags, input logic [8:0] exp_pc,
                               input logic exp_flush, input logic exp_halt = 1'b0,
                               input logic exp_ovf = 1'b0, input logic exp_unf = 1'b0,
                               input int mem_wait = 0);
    i_MemReady = 1'b0;
    i_Valid    = 1'b0;
    repeat (mem_wait) begin
      @(posedge i_Clk);
      #1;
    end
    i_MemReady    = 1'b1;
    i_Valid       = 1'b1;
    i_ControlJump = JMP;
    i_Offset      = 8'h55;
    i_Flags       = 3'b111;
    @(posedge i_Clk);
    #1;
    i_MemReady    = 1'b0;
    i_Valid       = 1'b1;
    i_ControlJump = code;
    i_Offset      = off;
    i_Flags       = flags;
    pushExpected(name, exp_pc, !exp_halt, exp_flush, exp_halt, exp_ovf, exp_unf);
    @(posedge i_Clk);
    #1;
    i_Valid       = 1'b0;
    i_ControlJump = JMP;
    i_Offset      = 8'h3C;
    i_Flags       = ~flags;
  endtask

  // While halted, hammer every input; nothing may move.
  task automatic idleHalted(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      i_MemReady    = 1'b1;
      i_Valid       = 1'b1;
      i_ControlJump = 3'(i);
      i_Offset      = 8'(i * 37);
      i_Flags       = 3'(i);
      @(negedge i_Clk);
      checkOutput("halted_held", int'(o_Halted), 1);
      checkOutput("halted_no_fetch", int'(o_Fetch), 0);
      @(posedge i_Clk);
      #1;
    end
    i_MemReady = 1'b0;
    i_Valid    = 1'b0;
  endtask

  // Monitor: a rising o_Fetch or o_Halted marks a completed resolution or
  // reset. Between such points the PC must not move and flush must be low.
  logic       prev_fetch  = 1'b0;
  logic       prev_halted = 1'b0;
  logic       synced      = 1'b0;
  logic [8:0] last_pc     = '0;

  always @(negedge i_Clk) begin
    exp_t e;
    if ((o_Fetch && !prev_fetch) || (o_Halted && !prev_halted)) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_response", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput({e.name, "_pc"},     int'(o_Addressinstruction_Bus), int'(e.pc));
        checkOutput({e.name, "_fetch"},  int'(o_Fetch),          int'(e.fetch));
        checkOutput({e.name, "_flush"},  int'(o_Flush),          int'(e.flush));
        checkOutput({e.name, "_halted"}, int'(o_Halted),         int'(e.halted));
        checkOutput({e.name, "_ovf"},    int'(o_StackOverflow),  int'(e.ovf));
        checkOutput({e.name, "_unf"},    int'(o_StackUnderflow), int'(e.unf));
      end
      last_pc = o_Addressinstruction_Bus;
      synced  = 1'b1;
    end else if (synced && !i_Reset) begin
      checkOutput("pc_stable_between_resolves", int'(o_Addressinstruction_Bus), int'(last_pc));
      checkOutput("flush_single_cycle", int'(o_Flush), 0);
    end
    prev_fetch  = o_Fetch;
    prev_halted = o_Halted;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    fail_count++;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_Reset       = 1'b1;
    i_Offset      = '0;
    i_Flags       = '0;
    i_ControlJump = NOP;
    i_Valid       = 1'b0;
    i_MemReady    = 1'b0;

    $display("[TB] reset and sequential fetch");
    resetDut("reset0");
    applyStimulus("nop_0to1", NOP, 8'h00, 3'b000, 9'd1, 1'b0);

    $display("[TB] conditional branches from PC=10");
    applyStimulus("jmp_to10",   JMP, 8'h09, 3'b000, 9'd10, 1'b1);
    applyStimulus("jmp_taken",  JMP, 8'h06, 3'b111, 9'd16, 1'b1);
    applyStimulus("back10_a",   JMP, 8'hFA, 3'b000, 9'd10, 1'b1);
    applyStimulus("jz_taken",   JZ,  8'h06, 3'b111, 9'd16, 1'b1);
    applyStimulus("back10_b",   JMP, 8'hFA, 3'b000, 9'd10, 1'b1);
    applyStimulus("jc_taken",   JC,  8'h06, 3'b111, 9'd16, 1'b1);
    applyStimulus("back10_c",   JMP, 8'hFA, 3'b000, 9'd10, 1'b1);
    applyStimulus("jn_taken",   JN,  8'h06, 3'b111, 9'd16, 1'b1, .mem_wait(2));
    applyStimulus("back10_d",   JMP, 8'hFA, 3'b000, 9'd10, 1'b1);
    applyStimulus("jnz_not",    JNZ, 8'h06, 3'b111, 9'd11, 1'b0);
    applyStimulus("jz_not",     JZ,  8'h06, 3'b000, 9'd12, 1'b0);
    applyStimulus("jc_not",     JC,  8'h06, 3'b000, 9'd13, 1'b0);
    applyStimulus("jn_not",     JN,  8'h06, 3'b000, 9'd14, 1'b0);
    applyStimulus("jnz_taken",  JNZ, 8'h06, 3'b000, 9'd20, 1'b1);

    $display("[TB] address wrap-around");
    applyStimulus("jmp_to5",    JMP, 8'hF1, 3'b000, 9'd5,   1'b1);
    applyStimulus("wrap_below", JMP, 8'h80, 3'b000, 9'd389, 1'b1);
    applyStimulus("jmp_to511",  JMP, 8'h7A, 3'b000, 9'd511, 1'b1);
    applyStimulus("nop_wrap",   NOP, 8'h00, 3'b000, 9'd0,   1'b0);

    $display("[TB] call and return");
    applyStimulus("jmp_to20",   JMP,  8'h14, 3'b000, 9'd20, 1'b1);
    applyStimulus("call_30",    CALL, 8'h0A, 3'b000, 9'd30, 1'b1);
    applyStimulus("ret_21",     RET,  8'h00, 3'b000, 9'd21, 1'b1);
    applyStimulus("call_26",    CALL, 8'h05, 3'b000, 9'd26, 1'b1);
    applyStimulus("call_20",    CALL, 8'hFA, 3'b000, 9'd20, 1'b1);
    applyStimulus("ret_27",     RET,  8'h00, 3'b000, 9'd27, 1'b1);
    applyStimulus("ret_22",     RET,  8'h00, 3'b000, 9'd22, 1'b1);

    $display("[TB] stack overflow");
    applyStimulus("call_d1",    CALL, 8'h01, 3'b000, 9'd23, 1'b1);
    applyStimulus("call_d2",    CALL, 8'h01, 3'b000, 9'd24, 1'b1);
    applyStimulus("call_d3",    CALL, 8'h01, 3'b000, 9'd25, 1'b1);
    applyStimulus("call_d4",    CALL, 8'h01, 3'b000, 9'd26, 1'b1);
    applyStimulus("call_ovf",   CALL, 8'h01, 3'b000, 9'd26, 1'b0, 1'b1, 1'b1, 1'b0);
    idleHalted(4);

    $display("[TB] reset from halt, stack underflow");
    resetDut("reset_halted_ovf");
    applyStimulus("ret_unf",    RET,  8'h00, 3'b000, 9'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    idleHalted(2);
    resetDut("reset_halted_unf");

    $display("[TB] reset mid-fetch and memory stall");
    applyStimulus("nop_pre",    NOP, 8'h00, 3'b000, 9'd1, 1'b0);
    i_MemReady = 1'b0;
    repeat (2) begin
      @(posedge i_Clk);
      #1;
    end
    resetDut("reset_fetch");
    repeat (5) begin
      @(negedge i_Clk);
      checkOutput("stall_fetch_held", int'(o_Fetch), 1);
      checkOutput("stall_pc_held", int'(o_Addressinstruction_Bus), 0);
      @(posedge i_Clk);
      #1;
    end
    applyStimulus("nop_after_stall", NOP, 8'h00, 3'b000, 9'd1, 1'b0, .mem_wait(3));

    repeat (3) begin
      @(posedge i_Clk);
      #1;
    end
    @(negedge i_Clk);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
